// File: rtl/data_memory_if.sv
// Purpose: CPU-to-data-memory bus bundle (request, address, store data, width code, response).
// Ports: master = CPU side (drives requests), slave = memory side (drives READ_DATA/BUSYWAIT/ERR).
// Signals keep the legacy uppercase names so existing CPU-side code maps one-to-one.
interface data_memory_if;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITE_DATA;
    logic [2:0]  FUNCT3;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        ERR;

    modport master (
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA, FUNCT3,
        input  READ_DATA, BUSYWAIT, ERR
    );

    modport slave (
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA, FUNCT3,
        output READ_DATA, BUSYWAIT, ERR
    );
endinterface

// File: rtl/data_memory.sv
// Purpose: word-organised data memory with RV32 byte/half/word loads and stores behind a busywait stall.
// Latency: BUSYWAIT high for LATENCY+1 cycles per access, then one DONE cycle (ERR pulses there on illegal access).
// Backpressure: the CPU holds MEM_READ/MEM_WRITE until BUSYWAIT falls; requests are ignored in DONE.
// Ports: CLK, RESET (async active-high), bus (data_memory_if.slave).
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    data_memory_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] CNT_LD = 4'(LATENCY - 1);

    logic [31:0]   mem [DEPTH_WORDS];

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    f3_q;
    logic          wr_q;
    logic [31:0]   rd_q;
    logic          err_q;

    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [4:0]    bsh;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic          illegal;
    logic [31:0]   load_v;
    logic [31:0]   new_word;
    logic          access;
    logic          req;

    // Address bits above the word index are deliberately ignored (addresses wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.MEM_ADDRESS[31:AW+2];

    assign req    = bus.MEM_READ | bus.MEM_WRITE;
    assign idx    = addr_q[AW+1:2];
    assign word   = mem[idx];
    assign bsh    = {addr_q[1:0], 3'b000};
    assign byte_v = 8'(word >> bsh);
    assign half_v = 16'(word >> {addr_q[1], 4'b0000});
    assign access = (state == S_BUSY) && (cnt == 4'd0);

    // LBU/LHU codes only exist for loads, so they are illegal as store widths.
    always_comb begin
        illegal = 1'b0;
        case (f3_q)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = addr_q[0];
            3'b010:  illegal = |addr_q[1:0];
            3'b100:  illegal = wr_q;
            3'b101:  illegal = wr_q | addr_q[0];
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        load_v = 32'd0;
        case (f3_q)
            3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_v = {{16{half_v[15]}}, half_v};
            3'b010:  load_v = word;
            3'b100:  load_v = {24'd0, byte_v};
            3'b101:  load_v = {16'd0, half_v};
            default: load_v = 32'd0;
        endcase
    end

    // Read-modify-write merge so unaddressed byte lanes keep their contents.
    always_comb begin
        new_word = word;
        case (f3_q)
            3'b000:  new_word[bsh +: 8] = wdata_q[7:0];
            3'b001:  new_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            3'b010:  new_word = wdata_q;
            default: new_word = word;
        endcase
    end

    // Array is not reset; an async reset drops the FSM to IDLE so an aborted store never commits.
    always_ff @(posedge CLK) begin
        if (access && wr_q && !illegal && !RESET) begin
            mem[idx] <= new_word;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            wr_q    <= 1'b0;
            rd_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    err_q <= 1'b0;
                    if (req) begin
                        addr_q  <= bus.MEM_ADDRESS[AW+1:0];
                        wdata_q <= bus.MEM_WRITE_DATA;
                        f3_q    <= bus.FUNCT3;
                        wr_q    <= bus.MEM_WRITE;  // write wins when both are raised
                        cnt     <= CNT_LD;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt == 4'd0) begin
                        err_q <= illegal;
                        if (!wr_q) begin
                            rd_q <= illegal ? 32'd0 : load_v;
                        end
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.READ_DATA = rd_q;
    assign bus.ERR       = err_q;
    assign bus.BUSYWAIT  = !RESET && (((state == S_IDLE) && req) || (state == S_BUSY));

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words stored, a power of two from 4 to 65536.
REQ-002 The module SHALL have parameter LATENCY, default 2, meaning the number of BUSY cycles per access, from 1 to 15.
REQ-003 The module SHALL have port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port MEM_READ, input, 1 bit: read request, held by the CPU until BUSYWAIT falls.
REQ-006 The module SHALL have port MEM_WRITE, input, 1 bit: write request, held by the CPU until BUSYWAIT falls.
REQ-007 The module SHALL have port MEM_ADDRESS, input, 32 bits: byte address.
REQ-008 The module SHALL have port MEM_WRITE_DATA, input, 32 bits: store data, right-aligned.
REQ-009 The module SHALL have port FUNCT3, input, 3 bits: the RV32 load/store width code.
REQ-010 The module SHALL have port READ_DATA, output, 32 bits: load result, registered.
REQ-011 The module SHALL have port BUSYWAIT, output, 1 bit: CPU stall request.
REQ-012 The module SHALL have port ERR, output, 1 bit: one-cycle pulse flagging a misaligned or illegal-width access.

Function
REQ-013 The module SHALL implement three states: IDLE, BUSY and DONE.
REQ-014 In IDLE with MEM_READ or MEM_WRITE high, the module SHALL register address, data, FUNCT3 and op, load the counter with LATENCY-1, and enter BUSY.
REQ-015 BUSYWAIT SHALL be combinational and high when (IDLE and (MEM_READ or MEM_WRITE)) or BUSY; it SHALL be low in DONE.
REQ-016 In BUSY the counter SHALL decrement each cycle; on the edge where the counter equals 0, the module SHALL perform the access and enter DONE.
REQ-017 An access SHALL therefore stall for exactly LATENCY+1 cycles, counting the request cycle.
REQ-018 DONE SHALL last exactly one cycle, SHALL ignore MEM_READ and MEM_WRITE, and SHALL return to IDLE; back-to-back requests thus carry one idle gap.
REQ-019 If MEM_READ and MEM_WRITE are both high, the write SHALL take priority and no read data SHALL be updated.
REQ-020 The word index SHALL be MEM_ADDRESS[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap.
REQ-021 Loads SHALL be decoded as follows, with all loads updating READ_DATA on the access edge and holding it until the next load or reset:
  - FUNCT3 000 (LB): byte sign-extended.
  - FUNCT3 001 (LH): halfword sign-extended.
  - FUNCT3 010 (LW): word.
  - FUNCT3 100 (LBU): byte zero-extended.
  - FUNCT3 101 (LHU): halfword zero-extended.
REQ-022 Stores SHALL be decoded as follows, with unaddressed bytes unchanged:
  - FUNCT3 000 (SB): write MEM_WRITE_DATA[7:0] to the addressed byte lane.
  - FUNCT3 001 (SH): write MEM_WRITE_DATA[15:0] to the addressed halfword.
  - FUNCT3 010 (SW): write the full word.
REQ-023 Byte lanes SHALL be little-endian, with lane n = address[1:0]==n holding bits 8n+7:8n.
REQ-024 An access SHALL be illegal when any of the following holds:
  - a halfword access has address[0]=1;
  - a word access has address[1:0]≠0;
  - FUNCT3 is not listed above.
REQ-025 An illegal access SHALL take the full latency, leave memory unchanged, set READ_DATA to 0 for loads, and pulse ERR high in the DONE cycle.
REQ-026 ERR SHALL be low in all other cycles.

Reset
REQ-027 When RESET is high, the module SHALL force IDLE, counter 0, READ_DATA=0, ERR=0 and BUSYWAIT=0 asynchronously, regardless of request inputs.
REQ-028 A RESET asserted during BUSY SHALL abort the access with no memory write.
REQ-029 Memory array contents SHALL NOT be cleared by reset and SHALL be undefined after power-up.
REQ-030 After RESET falls, a request held high SHALL be accepted as a new access on the next clock edge.

Verification
REQ-031 With LATENCY=2, SW of 0xDEADBEEF to address 0x10, then LW from 0x10, the bench SHALL see READ_DATA=0xDEADBEEF, with BUSYWAIT high for 3 cycles per access.
REQ-032 After SW of 0x80FF7F01 to 0x20, the bench SHALL see these load results:
  - LB from 0x23: 0xFFFFFF80.
  - LBU from 0x23: 0x00000080.
  - LH from 0x20: 0x00007F01.
  - LHU from 0x22: 0x000080FF.
REQ-033 After SW of 0x11223344 to 0x30, then SB of 0xAA to 0x31, then LW from 0x30, the bench SHALL see READ_DATA=0x1122AA44.
REQ-034 LW from 0x42 SHALL pulse ERR for 1 cycle and return READ_DATA=0; SH to 0x41 SHALL leave word 0x40 unchanged.
REQ-035 With DEPTH_WORDS=256, SW of 0x5 to 0x400 followed by LW from 0x0 SHALL return 0x5 (wrap).
REQ-036 Asserting RESET for 1 ns during the BUSY cycle of an SW to 0x50 SHALL force BUSYWAIT low immediately, and a subsequent LW from 0x50 SHALL return the prior contents.
